// File: rtl/deser160_event_fifo.sv
// Event FIFO behind the 160 MHz deserializer: FWFT word buffer with overflow
// handling that discards the remainder of a corrupted event until the next start marker.
module deser160_event_fifo #(
  parameter int AW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            write,
  input  logic [15:0]     data,
  output logic [15:0]     dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [AW:0]     level,
  output logic            overflow,
  output logic [CNTW-1:0] evcnt
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LVL_ZERO  = (AW + 1)'(0);
  localparam logic [AW:0] LVL_ONE   = (AW + 1)'(1);

  typedef enum logic {ACCEPT = 1'b0, DISCARD = 1'b1} state_t;

  state_t        state_r;
  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;

  logic          pop_s;
  logic          full_s;
  logic          room_s;
  logic          store_s;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [AW:0]   level_nxt_s;
  logic [AW:0]   remain_s;
  logic [15:0]   dout_nxt_s;

  // Store/drop decision for the incoming word.
  always_comb begin
    pop_s   = dout_valid && dout_ready;
    full_s  = (level == DEPTH_LVL);
    room_s  = !full_s || pop_s;
    store_s = 1'b0;
    if (reset || clear) begin
      store_s = 1'b0;
    end else begin
      case (state_r)
        ACCEPT:  store_s = write && room_s;
        DISCARD: store_s = write && data[15] && room_s;
        default: store_s = 1'b0;
      endcase
    end
  end

  // Next head-of-FIFO: bypass the incoming word when nothing else remains stored.
  always_comb begin
    rd_ptr_nxt_s = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
    if (store_s && !pop_s) begin
      level_nxt_s = level + LVL_ONE;
    end else if (!store_s && pop_s) begin
      level_nxt_s = level - LVL_ONE;
    end else begin
      level_nxt_s = level;
    end
    remain_s = pop_s ? level - LVL_ONE : level;
    if (level_nxt_s == LVL_ZERO) begin
      dout_nxt_s = dout;
    end else if (remain_s == LVL_ZERO) begin
      dout_nxt_s = data;
    end else begin
      dout_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Word storage; no reset needed since level/dout_valid qualify its contents.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // Pointers, status, output register and the accept/discard state machine.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_r    <= ACCEPT;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level      <= LVL_ZERO;
      dout       <= 16'h0000;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      evcnt      <= '0;
    end else begin
      rd_ptr_r   <= rd_ptr_nxt_s;
      level      <= level_nxt_s;
      dout       <= dout_nxt_s;
      dout_valid <= (level_nxt_s != LVL_ZERO);
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
        if (data[15]) begin
          evcnt <= evcnt + CNTW'(1);
        end
      end
      case (state_r)
        ACCEPT: begin
          if (write && !room_s) begin
            state_r  <= DISCARD;
            overflow <= 1'b1;
          end
        end
        DISCARD: begin
          if (write && data[15] && room_s) begin
            state_r <= ACCEPT;
          end
        end
        default: state_r <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_deser160_event_fifo.sv
// Directed self-checking bench for deser160_event_fifo: a per-cycle vector
// table plus hand-written sequences for overflow, back-pressure, clear and wrap.
module tb_deser160_event_fifo;

  logic        clk = 1'b0;
  logic        reset, clear, write, dout_ready;
  logic [15:0] data, dout;
  logic        dout_valid, overflow;
  logic [4:0]  level;
  logic [15:0] evcnt;

  int checks = 0;
  int errors = 0;

  deser160_event_fifo #(.AW(4), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .write(write), .data(data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .level(level), .overflow(overflow), .evcnt(evcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [15:0] d;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [15:0] e_dout;
    logic [4:0]  e_level;
    logic        e_ovf;
    logic [15:0] e_evcnt;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic c);
    @(negedge clk);
    write = w; data = d; dout_ready = r; clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    logic [15:0] w16;

    // inputs, then outputs expected right after that cycle's edge
    tbl[0] = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b1, 16'h8001, 5'd1, 1'b0, 16'd1};
    tbl[1] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0002, 5'd1, 1'b0, 16'd1};
    tbl[2] = '{1'b1, 16'h4003, 1'b1, 1'b0, 1'b1, 16'h4003, 5'd1, 1'b0, 16'd1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 16'd1};
    tbl[4] = '{1'b1, 16'h8005, 1'b0, 1'b0, 1'b1, 16'h8005, 5'd1, 1'b0, 16'd2};
    tbl[5] = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h8005, 5'd2, 1'b0, 16'd2};
    tbl[6] = '{1'b1, 16'h8007, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 16'd0};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 16'd0};

    reset = 1'b1; clear = 1'b0; write = 1'b1; data = 16'h8abc; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; write = 1'b0;
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_evcnt", 32'(evcnt), 32'd0);

    // test 1 and a first clear
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].w, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_evcnt", i), 32'(evcnt), 32'(tbl[i].e_evcnt));
    end

    // test 2: overflow and discard until a start marker finds room
    for (int i = 0; i < 16; i++) begin
      w16 = (i == 0) ? 16'h8020 : 16'h0020 + 16'(i);
      cyc(1'b1, w16, 1'b0, 1'b0);
    end
    chk("t2_full_level", 32'(level), 32'd16);
    chk("t2_full_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 16'h0011, 1'b0, 1'b0);
    chk("t2_ovf_set", 32'(overflow), 32'd1);
    chk("t2_ovf_level", 32'(level), 32'd16);
    cyc(1'b1, 16'h0012, 1'b0, 1'b0);
    cyc(1'b1, 16'h8013, 1'b0, 1'b0);
    chk("t2_drop_evcnt", 32'(evcnt), 32'd1);
    chk("t2_drop_level", 32'(level), 32'd16);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t2_drain_level", 32'(level), 32'd15);
    chk("t2_drain_dout", 32'(dout), 32'h0021);
    cyc(1'b1, 16'h8014, 1'b0, 1'b0);
    chk("t2_resync_level", 32'(level), 32'd16);
    chk("t2_resync_evcnt", 32'(evcnt), 32'd2);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b1, 16'h0015, 1'b0, 1'b0);
    chk("t2_accept_plain", 32'(level), 32'd16);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 14) w16 = 16'h0022 + 16'(k);
      else if (k == 14) w16 = 16'h8014;
      else w16 = 16'h0015;
      if (!dout_valid || dout !== w16) bad++;
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    chk("t2_drain_order_bad", 32'(bad), 32'd0);
    chk("t2_drained_valid", 32'(dout_valid), 32'd0);
    chk("t2_sticky_ovf", 32'(overflow), 32'd1);

    // test 5: clear together with a write
    cyc(1'b1, 16'h8030, 1'b0, 1'b0);
    cyc(1'b1, 16'h8099, 1'b0, 1'b1);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_valid", 32'(dout_valid), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_evcnt", 32'(evcnt), 32'd0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("t5_write_ignored", 32'(level), 32'd0);

    // test 3: write and pop on a full FIFO
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h0040 + 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'h0050, 1'b1, 1'b0);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_dout", 32'(dout), 32'h0041);

    // test 4: back-pressure then in-order drain
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      if (!dout_valid || dout !== 16'h0041) bad++;
    end
    chk("t4_hold_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      w16 = 16'h0041 + 16'(k);
      if (!dout_valid || dout !== w16) bad++;
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    chk("t4_order_bad", 32'(bad), 32'd0);
    chk("t4_empty_level", 32'(level), 32'd0);

    // test 6: evcnt wrap with continuous streaming through wrapping pointers
    bad = 0;
    for (int i = 0; i < 65535; i++) begin
      w16 = {4'h8, 12'(i)};
      cyc(1'b1, w16, 1'b1, 1'b0);
      if (!dout_valid || dout !== w16) bad++;
    end
    chk("t6_stream_bad", 32'(bad), 32'd0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t6_evcnt_max", 32'(evcnt), 32'h0000ffff);
    chk("t6_level", 32'(level), 32'd0);
    cyc(1'b1, 16'h8000, 1'b1, 1'b0);
    chk("t6_evcnt_wrap", 32'(evcnt), 32'd0);
    chk("t6_dout", 32'(dout), 32'h8000);
    chk("t6_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
